// File: rtl/cmult_requester_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// cmult_requester_pkg : shared state encoding and sizing constants
// rev 1.0
// ------------------------------------------------------------------------
package cmult_requester_pkg;

  localparam int C_DW_DEFAULT        = 32;
  localparam int C_TO_CYCLES_DEFAULT = 32;
  localparam int C_CNT_W             = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cmult_requester_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// cmult_requester_if : upstream operands, multiplier link and result bus
// rev 1.0
// ------------------------------------------------------------------------
interface cmult_requester_if
  import cmult_requester_pkg::*;
#(
  parameter int DW = C_DW_DEFAULT
);

  logic               in_valid;
  logic               in_ready;
  logic [DW-1:0]      in_re1;
  logic [DW-1:0]      in_im1;
  logic [DW-1:0]      in_re2;
  logic [DW-1:0]      in_im2;

  logic [DW-1:0]      m_re1;
  logic [DW-1:0]      m_im1;
  logic [DW-1:0]      m_re2;
  logic [DW-1:0]      m_im2;
  logic               m_start;
  logic               m_ready;
  logic [DW-1:0]      m_re;
  logic [DW-1:0]      m_im;

  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_re;
  logic [DW-1:0]      out_im;
  logic               out_err;
  logic [C_CNT_W-1:0] out_lat;
  logic [C_CNT_W-1:0] stray_cnt;

  // master is the requester itself; slave is everything around it
  modport master (
    input  in_valid, in_re1, in_im1, in_re2, in_im2,
    input  m_ready, m_re, m_im,
    input  out_ready,
    output in_ready,
    output m_re1, m_im1, m_re2, m_im2, m_start,
    output out_valid, out_re, out_im, out_err, out_lat, stray_cnt
  );

  modport slave (
    output in_valid, in_re1, in_im1, in_re2, in_im2,
    output m_ready, m_re, m_im,
    output out_ready,
    input  in_ready,
    input  m_re1, m_im1, m_re2, m_im2, m_start,
    input  out_valid, out_re, out_im, out_err, out_lat, stray_cnt
  );

endinterface
`default_nettype wire

// File: rtl/cmult_req_timer.sv
`default_nettype none
// ------------------------------------------------------------------------
// cmult_req_timer : saturating start-cycle counter with timeout compare
// rev 1.0
// ------------------------------------------------------------------------
module cmult_req_timer
  import cmult_requester_pkg::*;
#(
  parameter int TO_CYCLES = C_TO_CYCLES_DEFAULT
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               clr_i,
  input  wire logic               en_i,
  output logic      [C_CNT_W-1:0] cnt_o,
  output logic                    tc_o
);

  localparam logic [C_CNT_W:0] C_TC = TO_CYCLES[C_CNT_W:0];

  logic [C_CNT_W-1:0] cnt_q;
  logic [C_CNT_W:0]   w_cnt_inc;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // One bit wider so the compare cannot alias when the counter sits at 255
  assign w_cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign cnt_o     = cnt_q;
  assign tc_o      = en_i && (w_cnt_inc == C_TC);

endmodule
`default_nettype wire

// File: rtl/cmult_requester.sv
`default_nettype none
// ------------------------------------------------------------------------
// cmult_requester : one-at-a-time request sequencer for a complex multiplier
// rev 1.0
// ------------------------------------------------------------------------
module cmult_requester
  import cmult_requester_pkg::*;
#(
  parameter int DW        = C_DW_DEFAULT,
  parameter int TO_CYCLES = C_TO_CYCLES_DEFAULT
) (
  input  wire logic   clk,
  input  wire logic   rst,
  cmult_requester_if.master bus
);

  state_t             state_q;
  logic               in_ready_q;
  logic               m_start_q;
  logic [DW-1:0]      m_re1_q;
  logic [DW-1:0]      m_im1_q;
  logic [DW-1:0]      m_re2_q;
  logic [DW-1:0]      m_im2_q;
  logic               out_valid_q;
  logic               out_err_q;
  logic [DW-1:0]      out_re_q;
  logic [DW-1:0]      out_im_q;
  logic [C_CNT_W-1:0] out_lat_q;
  logic [C_CNT_W-1:0] stray_q;

  logic               w_accept;
  logic               w_waiting;
  logic [C_CNT_W-1:0] w_cnt;
  logic               w_tc;

  assign w_accept  = (state_q == IDLE) && bus.in_valid;
  assign w_waiting = (state_q == WAIT);

  cmult_req_timer #(
    .TO_CYCLES (TO_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (w_accept),
    .en_i  (w_waiting),
    .cnt_o (w_cnt),
    .tc_o  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      m_start_q   <= 1'b0;
      m_re1_q     <= '0;
      m_im1_q     <= '0;
      m_re2_q     <= '0;
      m_im2_q     <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_lat_q   <= '0;
      stray_q     <= '0;
    end else begin
      if (bus.m_ready && !w_waiting && (stray_q != '1)) begin
        stray_q <= stray_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            m_re1_q    <= bus.in_re1;
            m_im1_q    <= bus.in_im1;
            m_re2_q    <= bus.in_re2;
            m_im2_q    <= bus.in_im2;
            in_ready_q <= 1'b0;
            m_start_q  <= 1'b1;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          // A completion landing on the timeout cycle still counts as success
          if (bus.m_ready) begin
            out_re_q    <= bus.m_re;
            out_im_q    <= bus.m_im;
            out_err_q   <= 1'b0;
            out_lat_q   <= w_cnt + 1'b1;
            out_valid_q <= 1'b1;
            m_start_q   <= 1'b0;
            state_q     <= DONE;
          end else if (w_tc) begin
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_err_q   <= 1'b1;
            out_lat_q   <= TO_CYCLES[C_CNT_W-1:0];
            out_valid_q <= 1'b1;
            m_start_q   <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.m_start   = m_start_q;
  assign bus.m_re1     = m_re1_q;
  assign bus.m_im1     = m_im1_q;
  assign bus.m_re2     = m_re2_q;
  assign bus.m_im2     = m_im2_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.out_lat   = out_lat_q;
  assign bus.stray_cnt = stray_q;

endmodule
`default_nettype wire

// File: tb/tb_cmult_requester.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_cmult_requester : directed scoreboard bench with a behavioural multiplier
// rev 1.0
// ------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cmult_requester;
  import cmult_requester_pkg::*;

  localparam int DW = 32;
  localparam int TO = 32;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          resp_at = 0;
  int          cyc = 0;
  int          start_len = 0;
  logic        model_pulse = 1'b0;
  logic        stray_pulse = 1'b0;
  logic [31:0] resp_re = '0;
  logic [31:0] resp_im = '0;

  always #5 clk = ~clk;

  cmult_requester_if #(.DW(DW)) bus ();

  cmult_requester #(
    .DW        (DW),
    .TO_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.m_ready = model_pulse | stray_pulse;
  assign bus.m_re    = resp_re;
  assign bus.m_im    = resp_im;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Multiplier model: pulses m_ready on the resp_at-th start-high cycle (0 = never)
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.m_start) begin
        cyc++;
        model_pulse = (resp_at != 0) && (cyc == resp_at);
      end else begin
        if (cyc != 0) start_len = cyc;
        cyc = 0;
        model_pulse = 1'b0;
      end
    end
  end

  // Result monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: out_valid=1 out_re=%h but no result expected", bus.out_re);
      end else begin
        e = sb.pop_front();
        check("out_re",  bus.out_re,          e.re);
        check("out_im",  bus.out_im,          e.im);
        check("out_err", {31'd0, bus.out_err}, {31'd0, e.err});
        check("out_lat", {24'd0, bus.out_lat}, {24'd0, e.lat});
      end
    end
  end

  task automatic push(input logic [31:0] re, input logic [31:0] im, input logic err, input logic [7:0] lat);
    exp_t e;
    e.re = re; e.im = im; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic set_model(input int at, input logic [31:0] re, input logic [31:0] im);
    resp_at = at;
    resp_re = re;
    resp_im = im;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_re1 = a; bus.in_im1 = b; bus.in_re2 = c; bus.in_im2 = d;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("m_start_after_accept", {31'd0, bus.m_start}, 32'd1);
    check("in_ready_in_wait", {31'd0, bus.in_ready}, 32'd0);
    check("m_re1", bus.m_re1, a);
    check("m_im1", bus.m_im1, b);
    check("m_re2", bus.m_re2, c);
    check("m_im2", bus.m_im2, d);
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("result_pending", sb.size(), 32'd0);
    @(negedge clk);
    check("start_cycles", start_len, exp_lat);
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int hits;
    bus.in_valid = 1'b0;
    bus.in_re1 = '0; bus.in_im1 = '0; bus.in_re2 = '0; bus.in_im2 = '0;
    bus.out_ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_m_start",   {31'd0, bus.m_start},   32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_err",   {31'd0, bus.out_err},   32'd0);
    check("rst_out_re",    bus.out_re, 32'd0);
    check("rst_out_im",    bus.out_im, 32'd0);
    check("rst_m_re1",     bus.m_re1,  32'd0);
    check("rst_out_lat",   {24'd0, bus.out_lat},   32'd0);
    check("rst_stray",     {24'd0, bus.stray_cnt}, 32'd0);

    // 1.0 * 2.0, result after 16 start cycles
    set_model(16, 32'h4000_0000, 32'h0000_0000);
    push(32'h4000_0000, 32'h0000_0000, 1'b0, 8'd16);
    issue(32'h3f80_0000, 32'h0, 32'h4000_0000, 32'h0);
    wait_done(16);

    // No response: timeout abort with zeroed data
    set_model(0, 32'hdead_beef, 32'hcafe_f00d);
    push(32'h0, 32'h0, 1'b1, 8'd32);
    issue(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    wait_done(32);

    // Response on the timeout cycle wins
    set_model(32, 32'h1234_5678, 32'h9abc_def0);
    push(32'h1234_5678, 32'h9abc_def0, 1'b0, 8'd32);
    issue(32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888);
    wait_done(32);

    // Fastest response
    set_model(1, 32'h7f80_0000, 32'hff80_0000);
    push(32'h7f80_0000, 32'hff80_0000, 1'b0, 8'd1);
    issue(32'hbf80_0000, 32'h3f80_0000, 32'h4040_0000, 32'hc040_0000);
    wait_done(1);

    // Downstream stall with upstream pressure
    bus.out_ready = 1'b0;
    set_model(5, 32'h3f80_0000, 32'hbf80_0000);
    push(32'h3f80_0000, 32'hbf80_0000, 1'b0, 8'd5);
    issue(32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_re1 = 32'hDEAD_0000 + i;
      @(negedge clk);
      check("stall_valid",    {31'd0, bus.out_valid}, 32'd1);
      check("stall_out_re",   bus.out_re, 32'h3f80_0000);
      check("stall_out_im",   bus.out_im, 32'hbf80_0000);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_m_start",  {31'd0, bus.m_start},  32'd0);
      check("stall_m_re1",    bus.m_re1, 32'hAAAA_0001);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_done(5);

    // Reset on the 5th WAIT cycle discards the request
    set_model(0, 32'h0bad_0bad, 32'h0bad_0bad);
    issue(32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404);
    n = 0;
    while (cyc != 5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait5_reached", cyc, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_m_start",   {31'd0, bus.m_start},   32'd0);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.m_start) hits++;
    end
    check("midrst_quiet_cycles", hits, 32'd0);

    // Stray completions while idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stray_pulse = 1'b1;
      @(negedge clk);
      stray_pulse = 1'b0;
    end
    check("stray_cnt",       {24'd0, bus.stray_cnt}, 32'd3);
    check("stray_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("stray_m_start",   {31'd0, bus.m_start},   32'd0);
    check("stray_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Normal request after reset and strays
    set_model(7, 32'hc2c8_0000, 32'h42c8_0000);
    push(32'hc2c8_0000, 32'h42c8_0000, 1'b0, 8'd7);
    issue(32'h4120_0000, 32'h0, 32'hc120_0000, 32'h0);
    wait_done(7);
    check("stray_cnt_final", {24'd0, bus.stray_cnt}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
